// File: rtl/ysyx_22050550_if_fetch.sv
// Instruction-fetch stage: one 64-bit read per instruction, word select by pc[2], valid/ready to decode.
// Optional misaligned-PC trap enabled by defining YSYX_22050550_IF_MISALIGN_EN.
module ysyx_22050550_if_fetch #(
  parameter int          ADDR_W   = 64,
  parameter int          BUS_W    = 64,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_ready_o,
  input  logic              redirect_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [BUS_W-1:0]  imem_resp_data_i,
  input  logic              imem_resp_err_i,
  output logic              if_valid_o,
  input  logic              if_ready_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic [1:0]        if_exc_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       inst_q;
  logic [1:0]        exc_q;
  logic              misalign;
  logic              req_fire;
  logic              resp_take;

`ifdef YSYX_22050550_IF_MISALIGN_EN
  assign misalign = (state == REQ) && (pc_i[1:0] != 2'b00) && !redirect_i;
`else
  assign misalign = 1'b0;
`endif

  // The PC register only advances on a real handshake; a redirect masks both sides.
  assign imem_req_valid_o = (state == REQ) && !redirect_i && !misalign;
  assign imem_req_addr_o  = {pc_i[ADDR_W-1:3], 3'b000};
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign pc_ready_o       = req_fire;
  assign resp_take        = (state == WAIT) && imem_resp_valid_i && !redirect_i;

  assign if_valid_o = (state == OUT) && !redirect_i;
  assign if_pc_o    = pc_q;
  assign if_inst_o  = inst_q;
  assign if_exc_o   = exc_q;

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = REQ;
      REQ: begin
        if (misalign)      state_nx = OUT;
        else if (req_fire) state_nx = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid_i) state_nx = redirect_i ? REQ : OUT;
        else if (redirect_i)   state_nx = DRAIN;
      end
      DRAIN: if (imem_resp_valid_i) state_nx = REQ;
      OUT:   if (redirect_i || if_ready_i) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc_q   <= '0;
      inst_q <= '0;
      exc_q  <= '0;
    end else begin
      state <= state_nx;
      if (req_fire) pc_q <= pc_i;
      if (misalign) begin
        pc_q   <= pc_i;
        inst_q <= NOP_INST;
        exc_q  <= 2'b10;
      end
      if (resp_take) begin
        inst_q <= imem_resp_err_i ? NOP_INST
                : (pc_q[2] ? imem_resp_data_i[63:32] : imem_resp_data_i[31:0]);
        exc_q  <= {1'b0, imem_resp_err_i};
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_if_fetch.sv
// Directed bench for ysyx_22050550_if_fetch; the bench plays the instruction-bus slave by hand.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time unit later.
module tb_ysyx_22050550_if_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pc_i;
  logic        pc_ready_o;
  logic        redirect_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [63:0] imem_resp_data_i;
  logic        imem_resp_err_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [1:0]  if_exc_o;

  int total = 0;
  int bad   = 0;

  ysyx_22050550_if_fetch dut (
    .clock            (clock),
    .reset            (reset),
    .pc_i             (pc_i),
    .pc_ready_o       (pc_ready_o),
    .redirect_i       (redirect_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i (imem_resp_data_i),
    .imem_resp_err_i  (imem_resp_err_i),
    .if_valid_o       (if_valid_o),
    .if_ready_i       (if_ready_i),
    .if_pc_o          (if_pc_o),
    .if_inst_o        (if_inst_o),
    .if_exc_o         (if_exc_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc_i = '0; redirect_i = 1'b0; imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0; imem_resp_data_i = '0; imem_resp_err_i = 1'b0; if_ready_i = 1'b0;
    tick(); tick();
    chk("rst_if_valid", 64'(if_valid_o), 64'd0);
    chk("rst_pc_ready", 64'(pc_ready_o), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("rst_pc", if_pc_o, 64'd0);
    chk("rst_inst", 64'(if_inst_o), 64'd0);
    chk("rst_exc", 64'(if_exc_o), 64'd0);

    // Release reset: IDLE for one cycle, then REQ.
    reset = 1'b1;
    #1 chk("idle_req_valid", 64'(imem_req_valid_o), 64'd0);
    tick();

    // Fetch 0x80000000, zero-wait bus: low word selected.
    pc_i = 64'h8000_0000; imem_req_ready_i = 1'b1;
    #1 chk("t1_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("t1_addr", imem_req_addr_o, 64'h8000_0000);
    chk("t1_pc_ready", 64'(pc_ready_o), 64'd1);
    tick(); // WAIT
    chk("t1_wait_pc_ready", 64'(pc_ready_o), 64'd0);
    imem_resp_valid_i = 1'b1; imem_resp_data_i = 64'h00100093_00000513;
    #1 chk("t1_wait_no_valid", 64'(if_valid_o), 64'd0);
    tick(); // OUT
    imem_resp_valid_i = 1'b0;
    #1 chk("t1_if_valid", 64'(if_valid_o), 64'd1);
    chk("t1_pc", if_pc_o, 64'h8000_0000);
    chk("t1_inst", 64'(if_inst_o), 64'h0000_0513);
    chk("t1_exc", 64'(if_exc_o), 64'd0);
    if_ready_i = 1'b1;
    tick(); // REQ
    if_ready_i = 1'b0;

    // Fetch 0x80000004: high word selected, pc_ready one cycle only.
    pc_i = 64'h8000_0004;
    #1 chk("t2_pc_ready", 64'(pc_ready_o), 64'd1);
    chk("t2_addr", imem_req_addr_o, 64'h8000_0000);
    tick(); // WAIT
    chk("t2_pc_ready_off", 64'(pc_ready_o), 64'd0);
    imem_resp_valid_i = 1'b1;
    tick(); // OUT
    imem_resp_valid_i = 1'b0;
    #1 chk("t2_inst", 64'(if_inst_o), 64'h0010_0093);
    chk("t2_pc", if_pc_o, 64'h8000_0004);
    if_ready_i = 1'b1;
    tick(); // REQ
    if_ready_i = 1'b0;

    // Redirect while waiting: response arrives 2 cycles later and is drained.
    pc_i = 64'h8000_0008;
    tick(); // WAIT
    redirect_i = 1'b1; pc_i = 64'h8000_1000;
    #1 chk("t3_redir_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("t3_redir_pc_ready", 64'(pc_ready_o), 64'd0);
    tick(); // DRAIN
    redirect_i = 1'b0;
    #1 chk("t3_drain_req_valid", 64'(imem_req_valid_o), 64'd0);
    tick(); // still DRAIN
    imem_resp_valid_i = 1'b1; imem_resp_data_i = 64'hDEAD_BEEF_CAFE_F00D;
    #1 chk("t3_drain_if_valid", 64'(if_valid_o), 64'd0);
    tick(); // REQ
    imem_resp_valid_i = 1'b0;
    #1 chk("t3_new_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("t3_new_addr", imem_req_addr_o, 64'h8000_1000);
    chk("t3_new_if_valid", 64'(if_valid_o), 64'd0);
    tick(); // WAIT
    imem_resp_valid_i = 1'b1;
    tick(); // OUT
    imem_resp_valid_i = 1'b0;
    #1 chk("t3_target_inst", 64'(if_inst_o), 64'hCAFE_F00D);
    chk("t3_target_pc", if_pc_o, 64'h8000_1000);
    if_ready_i = 1'b1;
    tick(); // REQ
    if_ready_i = 1'b0;

    // Access fault: NOP with exc=01.
    pc_i = 64'h8000_0008;
    tick(); // WAIT
    imem_resp_valid_i = 1'b1; imem_resp_err_i = 1'b1;
    tick(); // OUT
    imem_resp_valid_i = 1'b0; imem_resp_err_i = 1'b0;
    #1 chk("t4_inst", 64'(if_inst_o), 64'h0000_0013);
    chk("t4_exc", 64'(if_exc_o), 64'b01);
    chk("t4_pc", if_pc_o, 64'h8000_0008);

    // Decode stalls 5 cycles: packet held, no request.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 64'(if_valid_o), 64'd1);
      chk("t5_hold_inst", 64'(if_inst_o), 64'h0000_0013);
      chk("t5_hold_req", 64'(imem_req_valid_o), 64'd0);
    end

    // Redirect in OUT kills the packet; redirect in REQ masks the request.
    redirect_i = 1'b1;
    #1 chk("t6_out_redir_valid", 64'(if_valid_o), 64'd0);
    tick(); // REQ
    chk("t6_req_redir_valid", 64'(imem_req_valid_o), 64'd0);
    chk("t6_req_redir_pcrdy", 64'(pc_ready_o), 64'd0);
    tick(); // still REQ
    redirect_i = 1'b0; pc_i = 64'h8000_2000; imem_req_ready_i = 1'b0;
    #1 chk("t6_target_valid", 64'(imem_req_valid_o), 64'd1);
    chk("t6_target_addr", imem_req_addr_o, 64'h8000_2000);
    chk("t6_stall_pcrdy", 64'(pc_ready_o), 64'd0);
    tick(); // still REQ, slave stalled
    imem_req_ready_i = 1'b1;
    #1 chk("t6_accept_pcrdy", 64'(pc_ready_o), 64'd1);
    tick(); // WAIT
    imem_resp_valid_i = 1'b1; redirect_i = 1'b1;
    tick(); // REQ (response dropped)
    imem_resp_valid_i = 1'b0; redirect_i = 1'b0;
    #1 chk("t7_drop_if_valid", 64'(if_valid_o), 64'd0);
    chk("t7_drop_req_valid", 64'(imem_req_valid_o), 64'd1);

    // Stale response while in REQ is ignored.
    imem_req_ready_i = 1'b0; imem_resp_valid_i = 1'b1;
    tick();
    imem_resp_valid_i = 1'b0;
    #1 chk("t8_stale_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("t8_stale_if_valid", 64'(if_valid_o), 64'd0);

    // Reset mid-read: outputs back to reset values at once.
    imem_req_ready_i = 1'b1;
    tick(); // WAIT
    reset = 1'b0;
    #1 chk("t9_rst_pc", if_pc_o, 64'd0);
    chk("t9_rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("t9_rst_if_valid", 64'(if_valid_o), 64'd0);
    tick();
    reset = 1'b1;
    tick(); // REQ

    // Misaligned pc.
    pc_i = 64'h8000_0002; imem_resp_data_i = 64'h00100093_00000513;
`ifdef YSYX_22050550_IF_MISALIGN_EN
    #1 chk("t10_mis_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("t10_mis_pc_ready", 64'(pc_ready_o), 64'd0);
    tick(); // OUT
    chk("t10_mis_valid", 64'(if_valid_o), 64'd1);
    chk("t10_mis_exc", 64'(if_exc_o), 64'b10);
    chk("t10_mis_inst", 64'(if_inst_o), 64'h0000_0013);
    chk("t10_mis_pc", if_pc_o, 64'h8000_0002);
`else
    #1 chk("t10_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("t10_addr", imem_req_addr_o, 64'h8000_0000);
    chk("t10_pc_ready", 64'(pc_ready_o), 64'd1);
    tick(); // WAIT
    imem_resp_valid_i = 1'b1;
    tick(); // OUT
    imem_resp_valid_i = 1'b0;
    #1 chk("t10_valid", 64'(if_valid_o), 64'd1);
    chk("t10_inst", 64'(if_inst_o), 64'h0000_0513);
    chk("t10_exc", 64'(if_exc_o), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
